// File: rtl/merge_arb.sv
// Round-robin merge of NCH four-phase request/acknowledge channels onto one shared output.
// Optional per-channel 16-bit grant counters on port gcnt when MERGE_ARB_STATS_EN is defined.
module merge_arb #(
  parameter int unsigned N   = 1,
  parameter int unsigned NCH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NCH-1:0]             r_i,
  output logic [NCH-1:0]             a_i,
  input  logic [NCH*N-1:0]           d_i,
  output logic                       r_o,
  input  logic                       a_o,
  output logic [N-1:0]               d_o,
  output logic [$clog2(NCH)-1:0]     g_o,
  output logic                       busy
`ifdef MERGE_ARB_STATS_EN
  ,
  output logic [NCH*16-1:0]          gcnt
`endif
);

  localparam int unsigned GW = $clog2(NCH);

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StAck
  } state_e;

  state_e          state_q;
  logic [GW-1:0]   last_q;
  logic [GW-1:0]   pick;
  logic            found;
  int              idx;

  // Round-robin search starting just after the most recently completed channel.
  always_comb begin
    pick  = last_q;
    found = 1'b0;
    idx   = 0;
    for (int i = 1; i <= int'(NCH); i++) begin
      idx = (int'(last_q) + i) % int'(NCH);
      if (!found && r_i[idx]) begin
        pick  = GW'(idx);
        found = 1'b1;
      end
    end
  end

  assign busy = (state_q != StIdle);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      last_q  <= GW'(NCH - 1);
      r_o     <= 1'b0;
      a_i     <= '0;
      d_o     <= '0;
      g_o     <= '0;
`ifdef MERGE_ARB_STATS_EN
      gcnt    <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (found) begin
            d_o     <= d_i[int'(pick)*N +: N];
            g_o     <= pick;
            r_o     <= 1'b1;
            state_q <= StReq;
          end
        end
        // A requester dropping r_i here is a protocol violation and is ignored.
        StReq: begin
          if (a_o) begin
            r_o     <= 1'b0;
            a_i     <= NCH'(1) << g_o;
            state_q <= StAck;
`ifdef MERGE_ARB_STATS_EN
            gcnt[int'(g_o)*16 +: 16] <= gcnt[int'(g_o)*16 +: 16] + 16'd1;
`endif
          end
        end
        StAck: begin
          if (!a_o && !r_i[g_o]) begin
            a_i     <= '0;
            last_q  <= g_o;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_merge_arb.sv
// Directed bench for merge_arb: a 2-channel and a 4-channel instance, each checked against a
// queue of expected grants (channel, data) filled as requests are raised.
module tb_merge_arb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]  r2, a2;
  logic [15:0] d2;
  logic        ro2, ao2, busy2;
  logic [7:0]  do2;
  logic [0:0]  go2;

  logic [3:0]  r4, a4;
  logic [31:0] d4;
  logic        ro4, ao4, busy4;
  logic [7:0]  do4;
  logic [1:0]  go4;

`ifdef MERGE_ARB_STATS_EN
  logic [31:0] gc2;
  logic [63:0] gc4;
`endif

  merge_arb #(.N(8), .NCH(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .r_i (r2),
    .a_i (a2),
    .d_i (d2),
    .r_o (ro2),
    .a_o (ao2),
    .d_o (do2),
    .g_o (go2),
    .busy(busy2)
`ifdef MERGE_ARB_STATS_EN
    ,
    .gcnt(gc2)
`endif
  );

  merge_arb #(.N(8), .NCH(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .r_i (r4),
    .a_i (a4),
    .d_i (d4),
    .r_o (ro4),
    .a_o (ao4),
    .d_o (do4),
    .g_o (go4),
    .busy(busy4)
`ifdef MERGE_ARB_STATS_EN
    ,
    .gcnt(gc4)
`endif
  );

  typedef struct {
    int         g;
    logic [7:0] d;
  } exp_t;

  exp_t sb2[$];
  exp_t sb4[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic underflow(input string tag);
    n_checks++;
    n_fail++;
    $error("FAIL %s: output produced with no expected grant queued", tag);
  endtask

  // Waits for r_o, checks it against the queue, then plays a full four-phase responder.
  task automatic xfer2();
    exp_t e;
    int   c;
    c = 0;
    while (!ro2 && c < 20) begin
      step();
      c++;
    end
    chk("dut2 r_o rise", 64'(ro2), 64'd1);
    if (sb2.size() == 0) begin
      underflow("dut2 scoreboard");
      return;
    end
    e = sb2.pop_front();
    chk("dut2 g_o", 64'(go2), 64'(e.g));
    chk("dut2 d_o", 64'(do2), 64'(e.d));
    ao2 = 1'b1;
    step();
    chk("dut2 a_i grant", 64'(a2), 64'(2'b01 << e.g));
    chk("dut2 a_i not 11", 64'(a2 != 2'b11), 64'd1);
    r2[e.g] = 1'b0;
    ao2     = 1'b0;
    step();
    chk("dut2 a_i release", 64'(a2), 64'd0);
  endtask

  task automatic xfer4();
    exp_t e;
    int   c;
    c = 0;
    while (!ro4 && c < 20) begin
      step();
      c++;
    end
    chk("dut4 r_o rise", 64'(ro4), 64'd1);
    if (sb4.size() == 0) begin
      underflow("dut4 scoreboard");
      return;
    end
    e = sb4.pop_front();
    chk("dut4 g_o", 64'(go4), 64'(e.g));
    chk("dut4 d_o", 64'(do4), 64'(e.d));
    ao4 = 1'b1;
    step();
    chk("dut4 a_i grant", 64'(a4), 64'(4'b0001 << e.g));
    r4[e.g] = 1'b0;
    ao4     = 1'b0;
    step();
    chk("dut4 a_i release", 64'(a4), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    r2 = '0; ao2 = 1'b0; d2 = '0;
    r4 = '0; ao4 = 1'b0; d4 = '0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    chk("reset r_o", 64'(ro2), 64'd0);
    chk("reset a_i", 64'(a2), 64'd0);
    chk("reset d_o", 64'(do2), 64'd0);
    chk("reset g_o", 64'(go2), 64'd0);
    chk("reset busy", 64'(busy2), 64'd0);
    chk("reset dut4 a_i", 64'(a4), 64'd0);
    chk("reset dut4 busy", 64'(busy4), 64'd0);

    // Single transfer on channel 0, with a_o falling before r_i.
    d2 = 16'h00A5;
    r2 = 2'b01;
    step();
    chk("grant r_o", 64'(ro2), 64'd1);
    chk("grant d_o", 64'(do2), 64'hA5);
    chk("grant g_o", 64'(go2), 64'd0);
    chk("grant busy", 64'(busy2), 64'd1);
    ao2 = 1'b1;
    step();
    chk("ack r_o", 64'(ro2), 64'd0);
    chk("ack a_i", 64'(a2), 64'h1);
    ao2 = 1'b0;
    step();
    chk("ack hold a_i", 64'(a2), 64'h1);
    chk("ack hold busy", 64'(busy2), 64'd1);
    r2 = 2'b00;
    step();
    chk("release a_i", 64'(a2), 64'd0);
    chk("release busy", 64'(busy2), 64'd0);
    chk("stable d_o", 64'(do2), 64'hA5);

    // Both channels held: grants alternate starting from channel 0 after reset.
    rst = 1'b1;
    step();
    rst = 1'b0;
    d2 = 16'h5A3C;
    for (int i = 0; i < 4; i++) sb2.push_back('{g: i % 2, d: (i % 2 == 0) ? 8'h3C : 8'h5A});
    r2 = 2'b11;
    for (int i = 0; i < 4; i++) begin
      xfer2();
      r2 = (i < 3) ? 2'b11 : 2'b00;
    end
    step();
    chk("alternate idle", 64'(busy2), 64'd0);
    chk("alternate queue drained", 64'(sb2.size()), 64'd0);

    // Four channels: after channel 1 completes, 1010 grants 3 then 1.
    d4 = {8'h33, 8'h22, 8'h11, 8'h00};
    sb4.push_back('{g: 1, d: 8'h11});
    r4 = 4'b0010;
    xfer4();
    sb4.push_back('{g: 3, d: 8'h33});
    sb4.push_back('{g: 1, d: 8'h11});
    r4 = 4'b1010;
    xfer4();
    xfer4();

    // r_i dropped during REQ is ignored; the transfer still completes.
    r4 = 4'b0100;
    step();
    chk("violation r_o", 64'(ro4), 64'd1);
    chk("violation g_o", 64'(go4), 64'd2);
    r4  = 4'b0000;
    ao4 = 1'b1;
    step();
    chk("violation a_i", 64'(a4), 64'h4);
    ao4 = 1'b0;
    step();
    chk("violation release", 64'(a4), 64'd0);
    chk("violation idle", 64'(busy4), 64'd0);

    // Reset during ACK aborts the transfer and restores channel 0 priority.
    r4 = 4'b0010;
    step();
    chk("abort grant g_o", 64'(go4), 64'd1);
    ao4 = 1'b1;
    step();
    chk("abort pre a_i", 64'(a4), 64'h2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    ao4 = 1'b0;
    chk("abort a_i", 64'(a4), 64'd0);
    chk("abort r_o", 64'(ro4), 64'd0);
    chk("abort g_o", 64'(go4), 64'd0);
    chk("abort busy", 64'(busy4), 64'd0);
    for (int i = 0; i < 4; i++) sb4.push_back('{g: i, d: 8'(i * 8'h11)});
    r4 = 4'b1111;
    for (int i = 0; i < 4; i++) xfer4();
    chk("dut4 queue drained", 64'(sb4.size()), 64'd0);

`ifdef MERGE_ARB_STATS_EN
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("gcnt reset", gc4, 64'd0);
    for (int i = 0; i < 3; i++) begin
      sb4.push_back('{g: 1, d: 8'h11});
      r4 = 4'b0010;
      xfer4();
    end
    chk("gcnt ch1", 64'(gc4[31:16]), 64'd3);
    chk("gcnt ch0", 64'(gc4[15:0]), 64'd0);
    chk("gcnt dut2 reset", 64'(gc2), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/merge_arb.md
MERGE_ARB -- requirements
Module: merge_arb

Interface
REQ-001 Parameter N, default 1, data width per channel in bits (1..64).
REQ-002 Parameter NCH, default 2, number of input channels (2..8).
REQ-003 Port clk  input  1  single clock; all logic on the rising edge.
REQ-004 Port rst  input  1  reset, synchronous and active-high.
REQ-005 Port r_i  input  NCH  per-channel request; bit k belongs to channel k.
REQ-006 Port a_i  output  NCH  per-channel acknowledge; bit k belongs to channel k.
REQ-007 Port d_i  input  NCH*N  channel data; channel k occupies bits k*N+N-1..k*N.
REQ-008 Port r_o  output  1  shared-output request.
REQ-009 Port a_o  input  1  shared-output acknowledge.
REQ-010 Port d_o  output  N  shared-output data, registered.
REQ-011 Port g_o  output  clog2(NCH)  index of the currently or most recently granted channel.
REQ-012 Port busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-013 All channels SHALL use a 4-phase return-to-zero handshake: req up, ack up, req down, ack down.
REQ-014 All inputs SHALL be synchronous to clk; the block SHALL NOT contain synchronizers.
REQ-015 The FSM SHALL have exactly three states: IDLE, REQ, and ACK.
REQ-016 IDLE: when any r_i bit is 1, the block SHALL select one channel by round-robin, searching from last+1 upward modulo NCH; the 'last' register holds the most recently completed channel.
REQ-017 On the selecting edge, the block SHALL latch the selected d_i slice into d_o, set g_o to the selected index, set r_o to 1, and enter REQ; r_o rises one cycle after r_i is sampled high.
REQ-018 REQ: when a_o is sampled 1, the block SHALL drive r_o to 0 and a_i[sel] to 1, and enter ACK.
REQ-019 ACK: when a_o and r_i[sel] are both sampled 0, the block SHALL drive a_i[sel] to 0, set last to sel, and enter IDLE.
REQ-020 At most one a_i bit SHALL be 1 at any time, and only while in ACK.
REQ-021 d_o and g_o SHALL be stable from the selecting edge until the next grant.
REQ-022 Requests on non-selected channels SHALL be ignored until the FSM returns to IDLE, and SHALL NOT be lost; a requester holds r_i high until acknowledged.
REQ-023 A new grant SHALL be possible on the same edge at which IDLE is entered only through the next IDLE cycle; the minimum gap between grants is one IDLE cycle.
REQ-024 In ACK, if a_o falls before r_i[sel] falls, or the reverse, the block SHALL remain in ACK until both are 0.
REQ-025 In REQ, a deassertion of r_i[sel] (a protocol violation) SHALL be ignored; the transfer SHALL complete normally.
REQ-026 A single requester SHALL be granted repeatedly with no starvation penalty; with all NCH channels requesting, each channel SHALL be granted once per NCH transfers.

Reset
REQ-027 While rst is 1 at a clock edge, the next state SHALL be IDLE, with r_o=0, a_i=0, d_o=0, g_o=0, busy=0, and last=NCH-1, so that channel 0 is first in priority.
REQ-028 Reset asserted in the middle of a transfer SHALL abort that transfer immediately, with no completion of the handshake.

Configuration
REQ-029 Macro MERGE_ARB_STATS_EN defined: the block SHALL add an output port gcnt (NCH*16 bits), holding a per-channel 16-bit grant counter for channel k in bits k*16+15..k*16.
REQ-030 Counter k SHALL increment on each REQ->ACK transition with sel=k, SHALL wrap from 0xFFFF to 0, and SHALL be cleared by rst.
REQ-031 Macro MERGE_ARB_STATS_EN not defined: the gcnt port and its counters SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-032 NCH=2, N=8, reset: r_i=01 with d_i[7:0]=0xA5 -> r_o=1 and d_o=0xA5 on the next cycle, g_o=0.
REQ-033 Then a_o=1 -> next cycle r_o=0, a_i=01; then drop r_i[0] and a_o -> next cycle a_i=00, busy=0.
REQ-034 r_i=11 held with an automatic responder -> grants alternate in the order 0,1,0,1, and a_i is never 11.
REQ-035 NCH=4, r_i=1010 after a completed grant of channel 1 -> next grant is channel 3, then channel 1.
REQ-036 rst pulsed while in ACK with a_i[1]=1 -> next cycle a_i=0, r_o=0, and the next grant starts from channel 0.
REQ-037 With MERGE_ARB_STATS_EN defined: 3 transfers on channel 1 -> gcnt[31:16]=3 and gcnt[15:0]=0; after 65536 transfers the counter wraps to 0.
